// File: rtl/fcs_pkg.sv
// fcs_pkg: shared state type and frame-size constants for the FCS frame serializer.
package fcs_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WAIT_FCS} state_t;
  localparam int MIN_FRAME_BYTES = 8;
  localparam int MAX_FRAME_BYTES = 127;
  localparam int BYTES_W = 7;
  localparam int SIZE_W = 10;
endpackage

// File: rtl/fcs_byte_shifter.sv
// fcs_byte_shifter: MSB-first byte shifter with a one-byte prefetch register and bypass reload.
module fcs_byte_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic                  in_fire_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  bit_out,
  output logic                  need_byte,
  output logic                  hold_empty
);
  localparam int CW = $clog2(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] sh_q, sh_d, hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, full_d;
  assign bit_out = sh_q[DATA_WIDTH-1];
  assign need_byte = shift_i && cnt_q == '0;
  assign hold_empty = !full_q;
  always_comb begin
    sh_d = sh_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    full_d = full_q;
    if (load_i) begin
      sh_d = data_i;
      cnt_d = CW'(DATA_WIDTH - 1);
      full_d = 1'b0;
    end else if (need_byte) begin
      // with neither hold nor bypass available the frame ends here, so the loaded value is don't-care
      sh_d = full_q ? hold_q : data_i;
      cnt_d = CW'(DATA_WIDTH - 1);
      full_d = 1'b0;
    end else if (shift_i) begin
      sh_d = sh_q << 1;
      cnt_d = cnt_q - 1'b1;
      hold_d = in_fire_i ? data_i : hold_q;
      full_d = full_q || in_fire_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      cnt_q <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end
endmodule

// File: rtl/fcs_frame_serializer.sv
// fcs_frame_serializer: byte-to-serial frame feeder for the FCS stage.
// Define FCS_SER_SIZE_CHECK_EN to reject frames shorter than Min_IN_WIDTH with a Size_Err pulse.
module fcs_frame_serializer
  import fcs_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int Max_IN_WIDTH = 1024,
  parameter int Min_IN_WIDTH = 64
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      Frame_Start,
  input  logic [$clog2(Max_IN_WIDTH/DATA_WIDTH)-1:0] Frame_Bytes,
  input  logic [DATA_WIDTH-1:0]                     In_Data,
  input  logic                                      In_Valid,
  output logic                                      In_Ready,
  input  logic                                      FCS_Done,
  output logic                                      Valid_Data,
  output logic [$clog2(Max_IN_WIDTH)-1:0]           Data_Size,
  output logic                                      Input_Data,
  output logic                                      Ser_Busy,
  output logic                                      Underrun_Err,
  output logic                                      Size_Err
);
  localparam int BW = $clog2(Max_IN_WIDTH / DATA_WIDTH);
  localparam int SW = $clog2(Max_IN_WIDTH);
  state_t state_q, state_d;
  logic [BW-1:0] rem_q, rem_d;
  logic [SW-1:0] size_q, size_d;
  logic valid_q, done_q, fire, more, last, size_bad, bit_out, need, hold_empty;
`ifdef FCS_SER_SIZE_CHECK_EN
  assign size_bad = Frame_Bytes < BW'(Min_IN_WIDTH / DATA_WIDTH);
`else
  assign size_bad = 1'b0;
`endif
  // rem_q counts bytes still to accept; a latched 0 wraps to a full 2**BW-byte frame
  assign more = rem_q != '0;
  assign In_Ready = state_q == LOAD || (state_q == SHIFT && hold_empty && more);
  assign fire = In_Valid && In_Ready;
  assign Underrun_Err = need && hold_empty && more && !In_Valid;
  assign last = need && hold_empty && !more;
  assign Size_Err = state_q == IDLE && Frame_Start && size_bad;
  assign Ser_Busy = state_q != IDLE;
  assign Input_Data = state_q == SHIFT && bit_out && !Underrun_Err;
  assign Valid_Data = valid_q;
  assign Data_Size = size_q;
  fcs_byte_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .clk       (CLK),
    .rst       (RST),
    .load_i    (state_q == LOAD && In_Valid),
    .shift_i   (state_q == SHIFT),
    .in_fire_i (fire),
    .data_i    (In_Data),
    .bit_out   (bit_out),
    .need_byte (need),
    .hold_empty(hold_empty)
  );
  always_comb begin
    state_d = state_q;
    rem_d = fire ? rem_q - 1'b1 : rem_q;
    size_d = size_q;
    case (state_q)
      IDLE: if (Frame_Start && !size_bad) begin
        state_d = LOAD;
        rem_d = Frame_Bytes;
        size_d = SW'(Frame_Bytes) * SW'(DATA_WIDTH);
      end
      LOAD: state_d = In_Valid ? SHIFT : LOAD;
      SHIFT: state_d = Underrun_Err ? IDLE : last ? WAIT_FCS : SHIFT;
      WAIT_FCS: state_d = (FCS_Done || done_q) ? IDLE : WAIT_FCS;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rem_q <= '0;
      size_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      size_q <= size_d;
      valid_q <= state_q == LOAD && In_Valid;
      done_q <= FCS_Done;
    end
  end
endmodule

// File: tb/tb_fcs_frame_serializer.sv
// tb_fcs_frame_serializer: directed and randomized frames checked against a bit-position reference model.
module tb_fcs_frame_serializer;
  import fcs_pkg::*;
  logic CLK = 1'b0, RST = 1'b1, Frame_Start = 1'b0, In_Valid = 1'b0, FCS_Done = 1'b0;
  logic [BYTES_W-1:0] Frame_Bytes = '0;
  logic [7:0] In_Data = '0;
  logic In_Ready, Valid_Data, Input_Data, Ser_Busy, Underrun_Err, Size_Err;
  logic [SIZE_W-1:0] Data_Size;
  int total = 0, bad = 0, last_size = 0;
  logic [7:0] fb [0:127];
  logic [63:0] g64, basic;
  always #5 CLK = ~CLK;
  fcs_frame_serializer dut (
    .CLK(CLK), .RST(RST), .Frame_Start(Frame_Start), .Frame_Bytes(Frame_Bytes),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready), .FCS_Done(FCS_Done),
    .Valid_Data(Valid_Data), .Data_Size(Data_Size), .Input_Data(Input_Data),
    .Ser_Busy(Ser_Busy), .Underrun_Err(Underrun_Err), .Size_Err(Size_Err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic fill_random();
    for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
  endtask
  // n bytes from fb; bp toggles In_Valid; wh withholds that byte index; rst_at pulses RST at that bit
  task automatic run_frame(input int n, input int bp, input int wh, input int rst_at, input bit done_last);
    int idx = 0, pos = 0, vcnt = 0, acc = -1, vcyc = -1, nmis = 0, ds_bad = 0, ur = 0, ur_pos = -1, se = 0;
    bit ended = 0, started = 0, aborted = 0, ur_bit = 0;
    g64 = '0;
    for (int c = 0; c < n * 8 + 64 && !ended; c++) begin
      @(negedge CLK);
      Frame_Start = (c == 0);
      Frame_Bytes = (c == 0) ? BYTES_W'(n) : BYTES_W'($urandom);
      RST = started && pos == rst_at;
      FCS_Done = done_last && started && pos == n * 8 - 1;
      In_Valid = idx < n && idx != wh && (bp == 0 || $urandom_range(0, 1) == 1 || (started && pos % 8 == 7));
      In_Data = (idx < n) ? fb[idx] : 8'($urandom);
      #1;
      if (c == 0) begin
        chk("idle_busy", Ser_Busy, 0);
        chk("idle_ready", In_Ready, 0);
        chk("idle_valid", Valid_Data, 0);
        chk("idle_bit", Input_Data, 0);
        chk("idle_size", Data_Size, last_size);
      end else if (Data_Size !== SIZE_W'(n * 8)) ds_bad++;
      se += int'(Size_Err);
      if (Valid_Data) begin
        vcnt++;
        if (!started) begin
          started = 1;
          vcyc = c;
        end
      end
      if (Underrun_Err) begin
        ur++;
        ur_pos = pos;
        ur_bit = Input_Data;
        aborted = 1;
      end else if (started && pos < n * 8) begin
        if (Input_Data !== fb[pos / 8][7 - pos % 8]) nmis++;
        if (pos < 64) g64 = {g64[62:0], Input_Data};
        pos++;
      end
      if (In_Valid && In_Ready) begin
        if (idx == 0) acc = c;
        idx++;
      end
      ended = aborted || RST || pos == n * 8;
    end
    chk("frame_ended", ended, 1);
    chk("valid_pulses", vcnt, 1);
    chk("first_bit_latency", vcyc, acc + 1);
    chk("bit_errors", nmis, 0);
    chk("size_held", ds_bad, 0);
    chk("size_err_quiet", se, 0);
    if (wh >= 0) begin
      chk("underrun_pos", ur_pos, wh * 8 - 1);
      chk("underrun_bit", ur_bit, 0);
    end else chk("underrun_quiet", ur, 0);
    last_size = (rst_at >= 0) ? 0 : n * 8;
    if (!aborted && rst_at < 0 && ended) begin
      @(negedge CLK);
      Frame_Start = !done_last;
      Frame_Bytes = BYTES_W'($urandom_range(MIN_FRAME_BYTES, MAX_FRAME_BYTES));
      FCS_Done = 0;
      In_Valid = 1'($urandom_range(0, 1));
      #1;
      chk("wait_busy", Ser_Busy, 1);
      chk("wait_ready", In_Ready, 0);
      chk("wait_bit", Input_Data, 0);
      if (!done_last) begin
        @(negedge CLK);
        Frame_Start = 0;
        FCS_Done = 1;
        #1;
        chk("wait_ignores_start", Ser_Busy, 1);
        chk("wait_size", Data_Size, n * 8);
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ready", In_Ready, 0);
    chk("rst_valid", Valid_Data, 0);
    chk("rst_bit", Input_Data, 0);
    chk("rst_busy", Ser_Busy, 0);
    chk("rst_underrun", Underrun_Err, 0);
    chk("rst_size_err", Size_Err, 0);
    chk("rst_size", Data_Size, 0);
    basic = 64'h0000000000400056;
    for (int i = 0; i < 8; i++) fb[i] = basic[63 - 8 * i -: 8];
    run_frame(8, 0, -1, -1, 0);
    chk("basic_word", g64, 64'h0000000000400056);
    run_frame(8, 1, -1, -1, 1);
    chk("backpressure_word", g64, 64'h0000000000400056);
    for (int k = 0; k < 4; k++) begin
      fill_random();
      run_frame($urandom_range(MIN_FRAME_BYTES, 40), k % 2, -1, -1, k == 2);
    end
    fill_random();
    run_frame(8, 0, 3, -1, 0);
`ifdef FCS_SER_SIZE_CHECK_EN
    @(negedge CLK);
    RST = 0;
    FCS_Done = 0;
    In_Valid = 0;
    Frame_Start = 1;
    Frame_Bytes = BYTES_W'(5);
    #1;
    chk("size_err_pulse", Size_Err, 1);
    @(negedge CLK);
    Frame_Start = 0;
    #1;
    chk("size_err_single", Size_Err, 0);
    chk("size_err_idle", Ser_Busy, 0);
    chk("size_err_keeps_size", Data_Size, last_size);
`else
    fill_random();
    run_frame(5, 1, -1, -1, 0);
`endif
    fill_random();
    run_frame(MAX_FRAME_BYTES, 1, -1, -1, 0);
    fill_random();
    run_frame(16, 0, -1, 20, 0);
    fill_random();
    run_frame(12, 1, -1, -1, 1);
    @(negedge CLK);
    FCS_Done = 0;
    Frame_Start = 0;
    In_Valid = 0;
    #1;
    chk("final_idle", Ser_Busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fcs_frame_serializer.md
# fcs_frame_serializer

Upstream feeder for the FCS generator. Accepts a frame as bytes over a valid/ready handshake and converts it to the gap-free, MSB-first serial bit stream the FCS stage expects. Generates the one-cycle `Valid_Data` start pulse and holds `Data_Size` stable for the whole frame. Waits for the FCS stage to report `Done` before it accepts the next frame.

## Interface
- `DATA_WIDTH`, 8, byte width of the parallel input.
- `Max_IN_WIDTH`, 1024, maximum frame size in bits; must match the FCS stage.
- `Min_IN_WIDTH`, 64, minimum frame size in bits.
- `CLK` in 1: single clock.
- `RST` in 1: synchronous reset, active-high.
- `Frame_Start` in 1: request a new frame; sampled only in IDLE.
- `Frame_Bytes` in `$clog2(Max_IN_WIDTH/DATA_WIDTH)` (7): frame length in bytes; legal range 8..127.
- `In_Data` in `DATA_WIDTH`: payload byte, MSB transmitted first.
- `In_Valid` in 1: `In_Data` valid.
- `In_Ready` out 1: byte accepted when `In_Valid && In_Ready`.
- `FCS_Done` in 1: Done pulse from the FCS stage.
- `Valid_Data` out 1: one-cycle pulse coincident with the first serial bit.
- `Data_Size` out `$clog2(Max_IN_WIDTH)` (10): `Frame_Bytes*8`, held for the whole frame.
- `Input_Data` out 1: serial bit.
- `Ser_Busy` out 1: high in every state except IDLE.
- `Underrun_Err` out 1: one-cycle pulse when the frame is aborted for lack of data.
- `Size_Err` out 1: one-cycle pulse when `Frame_Bytes` is illegal (only with the check compiled in).

## Operation
- FSM states: IDLE, LOAD, SHIFT, WAIT_FCS.
- IDLE:
  - `Frame_Start=1` latches `Frame_Bytes` and moves to LOAD.
  - `Data_Size` updates in the same edge.
- LOAD:
  - `In_Ready=1`.
  - The first accepted byte goes into the shift register; the FSM moves to SHIFT.
- SHIFT:
  - One bit per cycle, MSB first.
  - A 1-byte holding register prefetches the next byte. `In_Ready` = hold empty && bytes_accepted < latched count.
  - In the bit-0 cycle of the current byte:
    - If the hold is full, the shift register reloads from it.
    - Otherwise, if `In_Valid && In_Ready` in that same cycle, the byte bypasses straight into the shift register.
    - Otherwise, with bytes still remaining, this is an underrun: pulse `Underrun_Err`, drive `Input_Data`=0, and go to IDLE.
  - After the last bit of the last byte, go to WAIT_FCS.
- WAIT_FCS:
  - `In_Ready=0`, `Input_Data=0`.
  - `FCS_Done=1` returns the FSM to IDLE.
- Frame_Start outside IDLE is ignored.
- Bytes counter: 7 bits. Bit counter: 3 bits, wraps 0→7 at each byte reload.

## Timing
- Reset values: `In_Ready`, `Valid_Data`, `Input_Data`, `Ser_Busy`, `Underrun_Err`, `Size_Err` = 0; `Data_Size` = 0; state = IDLE.
- Cycle n: `Frame_Start` sampled. n+1: LOAD.
- First bit timing: a byte accepted in LOAD at cycle m puts its bit 7 on `Input_Data`, with `Valid_Data=1`, at cycle m+1.
- Bits of a frame occupy exactly `Frame_Bytes*8` consecutive cycles with no gaps.
- `Valid_Data` is high for exactly one cycle per frame.
- `Data_Size` is stable from LOAD through WAIT_FCS.
- `FCS_Done` arriving in the same cycle as the last bit is not lost: it is registered and honoured on entry to WAIT_FCS.
- `RST` mid-frame: all state is cleared the next edge, with no error pulse.

## Configuration
- `FCS_SER_SIZE_CHECK_EN` defined:
  - In IDLE, `Frame_Start` with `Frame_Bytes` < 8 (i.e. < `Min_IN_WIDTH/8`) pulses `Size_Err` for one cycle.
  - The FSM stays in IDLE and `Data_Size` is not updated.
- `FCS_SER_SIZE_CHECK_EN` undefined:
  - `Size_Err` is tied 0.
  - Any `Frame_Bytes` is accepted. 0 is treated as 128 by counter wrap and is out of contract.

## Structure
- `fcs_pkg` holds:
  - the state enum;
  - `MIN_FRAME_BYTES` = 8;
  - `MAX_FRAME_BYTES` = 127;
  - the byte-count and size widths.
- Sub-module `fcs_byte_shifter` covers the shift register, holding register, bit counter, bypass and reload. It outputs `bit_out`, `need_byte` and `hold_empty`.
- Top-level `fcs_frame_serializer` contains the FSM, byte counter, error pulses and size latch.

## Test plan
- Basic frame: `Frame_Bytes`=8 with bytes 00,00,00,00,00,40,00,56, streamed with `In_Valid` always high.
  - `Data_Size`=64 and `Valid_Data` is high for a single cycle.
  - 64 consecutive bits equal 0x0000000000400056, MSB first.
  - When chained to the FCS stage, the remainder is 0x279E.
- Backpressure: `In_Valid` toggling but always present by each bit-0 cycle → bit stream identical to the basic-frame case, with no `Underrun_Err`.
- Underrun: withhold byte 3 of an 8-byte frame.
  - `Underrun_Err` pulses in the bit-0 cycle of byte 2 (the last bit of the third byte); the FSM returns to IDLE and `Ser_Busy` falls next cycle.
- Size check (`FCS_SER_SIZE_CHECK_EN`): `Frame_Bytes`=5 → `Size_Err` one-cycle pulse, FSM stays IDLE, `Data_Size` unchanged. `Frame_Bytes`=127 → `Data_Size`=1016.
- Back-to-back frames: a second `Frame_Start` during WAIT_FCS is ignored; a `Frame_Start` in the cycle after `FCS_Done` starts frame 2.
- Reset mid-frame: assert `RST` at bit 20 → all outputs 0 next edge; a fresh frame afterwards is correct.
